// File: rtl/poly_operand_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// poly_mul_pkg: shared types/constants for the polynomial multiplier.
// Rev 1.0
// ----------------------------------------------------------------------------
package poly_mul_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        OFFER  = 2'd2
    } state_t;

    localparam int DEF_N = 4;
    localparam int DEF_W = 1;

    function automatic int coeff_slice(input int i, input int w = DEF_W);
        return i * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_operand_loader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// poly_operand_loader_if: coefficient stream in, operand pair out.
// Rev 1.0
// ----------------------------------------------------------------------------
interface poly_operand_loader_if #(
    parameter int N = poly_mul_pkg::DEF_N,
    parameter int W = poly_mul_pkg::DEF_W
);
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_data;
    logic           s_last;
    logic [N*W-1:0] data1;
    logic [N*W-1:0] data0;
    logic           op_valid;
    logic           op_ack;
    logic           frame_err;

    modport master (
        output s_valid, s_data, s_last, op_ack,
        input  s_ready, data1, data0, op_valid, frame_err
    );

    modport slave (
        input  s_valid, s_data, s_last, op_ack,
        output s_ready, data1, data0, op_valid, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/poly_coeff_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// poly_coeff_packer: N*W register, indexed W-bit write, parallel load, clear.
// Rev 1.0
// ----------------------------------------------------------------------------
module poly_coeff_packer
    import poly_mul_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int IW = 2
) (
    input  wire logic           clk,
    input  wire logic           clr,
    input  wire logic           we,
    input  wire logic [IW-1:0]  widx,
    input  wire logic [W-1:0]   wdata,
    input  wire logic           ld,
    input  wire logic [N*W-1:0] ld_data,
    output      logic [N*W-1:0] q
);
    logic [N*W-1:0] r_q;

    always_ff @(negedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= ld_data;
        end else if (we) begin
            r_q[coeff_slice(int'(widx), W) +: W] <= wdata;
        end
    end

    assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/poly_operand_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// poly_operand_loader: packs a 2N-beat coefficient stream into operands A/B.
// Optional shadow buffer: define POLY_LOADER_DBUF_EN.   Rev 1.0
// ----------------------------------------------------------------------------
module poly_operand_loader
    import poly_mul_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int CW = $clog2(2*N)
) (
    input wire logic             clk,
    input wire logic             reset,
    poly_operand_loader_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_idx_a_end = CW'(N - 1);
    localparam logic [CW-1:0] c_idx_b0    = CW'(N);
    localparam logic [CW-1:0] c_idx_end   = CW'(2*N - 1);

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_idx, w_idx_nxt;
    logic           r_frame_err, w_frame_err_nxt;
    logic           w_s_ready, w_beat, w_in_b, w_at_end, w_fill_main, w_clr, w_ld;
    logic [IW-1:0]  w_widx;
    logic [N*W-1:0] w_data1, w_data0, w_ld_a, w_ld_b;

    assign w_clr    = ~reset;
    assign w_beat   = bus.s_valid && w_s_ready;
    assign w_in_b   = (r_idx >= c_idx_b0);
    assign w_at_end = (r_idx == c_idx_end);
    assign w_widx   = w_in_b ? IW'(r_idx - c_idx_b0) : IW'(r_idx);
    assign w_fill_main = w_beat && (r_state != OFFER);

`ifdef POLY_LOADER_DBUF_EN
    logic           r_shadow_full, w_shadow_full_nxt;
    logic [N*W-1:0] w_shadow_a, w_shadow_b;

    // While offering, beats go to the shadow until it holds a whole frame.
    assign w_s_ready = reset && ((r_state != OFFER) || (!r_shadow_full && !bus.op_ack));
    assign w_ld      = (r_state == OFFER) && bus.op_ack;
    assign w_ld_a    = w_shadow_a;
    assign w_ld_b    = w_shadow_b;

    poly_coeff_packer #(.N(N), .W(W), .IW(IW)) u_shadow_a (
        .clk(clk), .clr(w_clr), .we(w_beat && !w_fill_main && !w_in_b), .widx(w_widx),
        .wdata(bus.s_data), .ld(1'b0), .ld_data('0), .q(w_shadow_a)
    );
    poly_coeff_packer #(.N(N), .W(W), .IW(IW)) u_shadow_b (
        .clk(clk), .clr(w_clr), .we(w_beat && !w_fill_main && w_in_b), .widx(w_widx),
        .wdata(bus.s_data), .ld(1'b0), .ld_data('0), .q(w_shadow_b)
    );
`else
    assign w_s_ready = reset && (r_state != OFFER);
    assign w_ld      = 1'b0;
    assign w_ld_a    = '0;
    assign w_ld_b    = '0;
`endif

    poly_coeff_packer #(.N(N), .W(W), .IW(IW)) u_pack_a (
        .clk(clk), .clr(w_clr), .we(w_fill_main && !w_in_b), .widx(w_widx),
        .wdata(bus.s_data), .ld(w_ld), .ld_data(w_ld_a), .q(w_data1)
    );
    poly_coeff_packer #(.N(N), .W(W), .IW(IW)) u_pack_b (
        .clk(clk), .clr(w_clr), .we(w_fill_main && w_in_b), .widx(w_widx),
        .wdata(bus.s_data), .ld(w_ld), .ld_data(w_ld_b), .q(w_data0)
    );

    always_ff @(negedge clk) begin
        if (!reset) begin
            r_state     <= LOAD_A;
            r_idx       <= '0;
            r_frame_err <= 1'b0;
`ifdef POLY_LOADER_DBUF_EN
            r_shadow_full <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_frame_err <= w_frame_err_nxt;
`ifdef POLY_LOADER_DBUF_EN
            r_shadow_full <= w_shadow_full_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_frame_err_nxt = 1'b0;
`ifdef POLY_LOADER_DBUF_EN
        w_shadow_full_nxt = r_shadow_full;
`endif
        // s_last must coincide exactly with the final beat of the frame.
        if (w_beat && (bus.s_last != w_at_end)) begin
            w_frame_err_nxt = 1'b1;
            w_idx_nxt       = '0;
            if (r_state != OFFER) begin
                w_state_nxt = LOAD_A;
            end
        end else if (w_beat && w_at_end) begin
            w_idx_nxt = '0;
            if (r_state != OFFER) begin
                w_state_nxt = OFFER;
            end
`ifdef POLY_LOADER_DBUF_EN
            else begin
                w_shadow_full_nxt = 1'b1;
            end
`endif
        end else if (w_beat) begin
            w_idx_nxt = r_idx + 1'b1;
            if ((r_state == LOAD_A) && (r_idx == c_idx_a_end)) begin
                w_state_nxt = LOAD_B;
            end
        end

        if ((r_state == OFFER) && bus.op_ack) begin
`ifdef POLY_LOADER_DBUF_EN
            if (r_shadow_full) begin
                w_shadow_full_nxt = 1'b0;
            end else begin
                w_state_nxt = w_in_b ? LOAD_B : LOAD_A;
            end
`else
            w_state_nxt = LOAD_A;
`endif
        end
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.data1     = w_data1;
    assign bus.data0     = w_data0;
    assign bus.op_valid  = (r_state == OFFER);
    assign bus.frame_err = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_poly_operand_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_poly_operand_loader: directed self-checking bench for poly_operand_loader.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_poly_operand_loader;
    localparam int N = 4;
    localparam int W = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    poly_operand_loader_if #(.N(N), .W(W)) bus();
    poly_operand_loader #(.N(N), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // DUT updates on negedge; the bench drives and samples just after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic d, input logic last, input bit gaps);
        int guard;
        if (gaps) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                bus.s_valid = 1'b0;
                tick();
            end
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        guard = 0;
        while (bus.s_ready !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        if (guard >= 40) begin
            total++; bad++;
            $display("FAIL beat_wait: s_ready=%b required 1", bus.s_ready);
        end
        @(negedge clk);
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [N-1:0] a, input logic [N-1:0] b,
                              input int nbeats, input int last_at, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            send_beat((i < N) ? a[i] : b[i-N], (i == last_at), gaps);
        end
    endtask

    task automatic pulse_ack();
        bus.op_ack = 1'b1;
        tick();
        bus.op_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
        total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL reset_op_valid: got %b want 0", bus.op_valid); end
        total++; if (bus.data1 !== 4'h0 || bus.data0 !== 4'h0) begin bad++; $display("FAIL reset_data: got %h/%h want 0/0", bus.data1, bus.data0); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
        reset = 1'b1;
        tick();
        total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL post_reset_s_ready: got %b want 1", bus.s_ready); end
    endtask

    task automatic test_basic();
        logic [N-1:0] a, b;
        a = 4'b0101;
        b = 4'b0010;
        send_frame(a, b, 8, 7, 1'b0);
        total++; if (bus.op_valid !== 1'b1) begin bad++; $display("FAIL basic_op_valid: got %b want 1", bus.op_valid); end
        total++; if (bus.data1 !== 4'b0101) begin bad++; $display("FAIL basic_data1: got %b want 0101", bus.data1); end
        total++; if (bus.data0 !== 4'b0010) begin bad++; $display("FAIL basic_data0: got %b want 0010", bus.data0); end
`ifndef POLY_LOADER_DBUF_EN
        total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL basic_offer_s_ready: got %b want 0", bus.s_ready); end
`endif
        pulse_ack();
        total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL basic_ack_op_valid: got %b want 0", bus.op_valid); end
    endtask

`ifndef POLY_LOADER_DBUF_EN
    task automatic test_stall();
        logic [N-1:0] a, b;
        a = 4'b1100;
        b = 4'b0011;
        send_frame(a, b, 8, 7, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 1'b1;
        bus.s_last  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if ({bus.s_ready, bus.op_valid, bus.data1, bus.data0} !== {1'b0, 1'b1, a, b}) begin
                bad++;
                $display("FAIL stall_cycle%0d: got rdy=%b v=%b %b/%b want rdy=0 v=1 %b/%b",
                         c, bus.s_ready, bus.op_valid, bus.data1, bus.data0, a, b);
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        pulse_ack();
        total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL stall_ack_op_valid: got %b want 0", bus.op_valid); end
    endtask
`endif

    task automatic test_err_early();
        send_frame(4'b1111, 4'b0000, 4, 3, 1'b0);
        total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL early_frame_err: got %b want 1", bus.frame_err); end
        total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL early_op_valid: got %b want 0", bus.op_valid); end
        tick();
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL early_err_pulse: got %b want 0", bus.frame_err); end
        send_frame(4'b0110, 4'b1001, 8, 7, 1'b0);
        total++; if ({bus.op_valid, bus.data1, bus.data0} !== {1'b1, 4'b0110, 4'b1001}) begin
            bad++; $display("FAIL early_recover: got v=%b %b/%b want v=1 0110/1001", bus.op_valid, bus.data1, bus.data0);
        end
        pulse_ack();
    endtask

    task automatic test_err_late();
        send_frame(4'b1010, 4'b0101, 8, 8, 1'b0);
        total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL late_frame_err: got %b want 1", bus.frame_err); end
        total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL late_op_valid: got %b want 0", bus.op_valid); end
        send_frame(4'b1111, 4'b1111, 5, 8, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 1'b1;
        reset = 1'b0;
        #1;
        total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL midreset_s_ready: got %b want 0", bus.s_ready); end
        tick();
        total++; if ({bus.op_valid, bus.frame_err, bus.data1, bus.data0} !== 10'b0) begin
            bad++; $display("FAIL midreset_outputs: got v=%b e=%b %b/%b want all 0", bus.op_valid, bus.frame_err, bus.data1, bus.data0);
        end
        bus.s_valid = 1'b0;
        reset = 1'b1;
        tick();
        send_frame(4'b1011, 4'b0111, 8, 7, 1'b0);
        total++; if ({bus.op_valid, bus.frame_err, bus.data1, bus.data0} !== {2'b10, 4'b1011, 4'b0111}) begin
            bad++; $display("FAIL midreset_recover: got v=%b e=%b %b/%b want v=1 e=0 1011/0111", bus.op_valid, bus.frame_err, bus.data1, bus.data0);
        end
        pulse_ack();
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        int offered;
        offered = 0;
        for (int f = 0; f < 10; f++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            send_frame(a, b, 8, 7, 1'b1);
            if (bus.op_valid === 1'b1) offered++;
            for (int d = $urandom_range(0, 5); d > 0; d--) tick();
            total++; if ({bus.op_valid, bus.data1, bus.data0} !== {1'b1, a, b}) begin
                bad++; $display("FAIL random_frame%0d: got v=%b %b/%b want v=1 %b/%b", f, bus.op_valid, bus.data1, bus.data0, a, b);
            end
            pulse_ack();
            total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL random_dup%0d: op_valid=%b want 0", f, bus.op_valid); end
        end
        total++; if (offered != 10) begin bad++; $display("FAIL random_count: got %0d want 10", offered); end
    endtask

`ifdef POLY_LOADER_DBUF_EN
    task automatic test_back_to_back();
        send_frame(4'b0011, 4'b1000, 8, 7, 1'b0);
        send_frame(4'b1110, 4'b0101, 8, 7, 1'b0);
        total++; if ({bus.op_valid, bus.s_ready, bus.data1, bus.data0} !== {2'b10, 4'b0011, 4'b1000}) begin
            bad++; $display("FAIL dbuf_shadow_full: got v=%b rdy=%b %b/%b want v=1 rdy=0 0011/1000", bus.op_valid, bus.s_ready, bus.data1, bus.data0);
        end
        pulse_ack();
        total++; if ({bus.op_valid, bus.data1, bus.data0} !== {1'b1, 4'b1110, 4'b0101}) begin
            bad++; $display("FAIL dbuf_swap: got v=%b %b/%b want v=1 1110/0101", bus.op_valid, bus.data1, bus.data0);
        end
        pulse_ack();
        total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL dbuf_drain: op_valid=%b want 0", bus.op_valid); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 1'b0;
        bus.s_last  = 1'b0;
        bus.op_ack  = 1'b0;
        test_reset();
        test_basic();
`ifndef POLY_LOADER_DBUF_EN
        test_stall();
`endif
        test_err_early();
        test_err_late();
        test_random();
`ifdef POLY_LOADER_DBUF_EN
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
